hazard_control: RTL and testbench
=================================

HAZARD_CONTROL -- requirements
Module: hazard_control

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 4, meaning total EX-stage occupancy in cycles of a MUL instruction (legal range 2..15).
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n_i, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port ID_op_i, input, 6, opcode of the instruction in ID; codes per the shared opcode table in LookupTable.v.
REQ-005 SHALL have port IFID_rs_i, input, 5, rs field of the instruction in IF/ID.
REQ-006 SHALL have port IFID_rt_i, input, 5, rt field of the instruction in IF/ID.
REQ-007 SHALL have port branch_eq_i, input, 1, ID-stage register-equality result for BEQ.
REQ-008 SHALL have port IDEX_op_i, input, 6, opcode of the instruction in ID/EX.
REQ-009 SHALL have port IDEX_MEM_ctrl_i, input, 2, {MEM_cs, MEM_we} of the instruction in ID/EX.
REQ-010 SHALL have port IDEX_rt_i, input, 5, rt of the instruction in ID/EX.
REQ-011 SHALL have port pc_write_o, output, 1, PC update enable.
REQ-012 SHALL have port IFID_write_o, output, 1, IF/ID register enable.
REQ-013 SHALL have port IFID_flush_o, output, 1, clear IF/ID to NOP.
REQ-014 SHALL have port IDEX_bubble_o, output, 1, force zero EX/MEM/WB control into ID/EX.
REQ-015 SHALL have port EX_hold_o, output, 1, hold ID/EX and inject a bubble into EX/MEM.
REQ-016 SHALL have port stall_cnt_o, output, 16, saturating count of cycles with pc_write_o=0.

Function
REQ-017 SHALL implement states RUN and MUL_WAIT plus a 4-bit down-counter cnt.
REQ-018 SHALL define load_use = MEM_cs & ~MEM_we & (IDEX_rt_i != 0) & (IDEX_rt_i == IFID_rs_i | IDEX_rt_i == IFID_rt_i).
REQ-019 SHALL, in RUN with IDEX_op_i == MUL, assert EX_hold_o=0->1, pc_write_o=0, IFID_write_o=0 in the same cycle, load cnt=MUL_CYCLES-2, and enter MUL_WAIT.
REQ-020 SHALL, in MUL_WAIT with cnt != 0, keep EX_hold_o=1, pc_write_o=0, IFID_write_o=0, IFID_flush_o=0, IDEX_bubble_o=0, and decrement cnt.
REQ-021 SHALL, in MUL_WAIT with cnt == 0, deassert EX_hold_o, evaluate load_use and branch as in RUN except MUL detection, and return to RUN; EX_hold_o is therefore high for exactly MUL_CYCLES-1 cycles per MUL.
REQ-022 SHALL, on load_use (not holding), drive pc_write_o=0, IFID_write_o=0, IDEX_bubble_o=1, IFID_flush_o=0 combinationally for that cycle.
REQ-023 SHALL, when ID_op_i is J, or is BEQ with branch_eq_i=1, and no stall applies, drive IFID_flush_o=1 for that cycle.
REQ-024 SHALL apply the priority MUL hold > load_use > branch/jump flush; a suppressed flush is re-evaluated on the next cycle.
REQ-025 SHALL, otherwise, drive pc_write_o=1, IFID_write_o=1, all other control outputs 0.
REQ-026 SHALL increment stall_cnt_o on every clock edge where pc_write_o=0 outside reset, saturating at 16'hFFFF.

Reset
REQ-027 SHALL, while rst_n_i=0, force state=RUN, cnt=0, stall_cnt_o=0, pc_write_o=0, IFID_write_o=0, IFID_flush_o=0, IDEX_bubble_o=1, EX_hold_o=0.
REQ-028 SHALL abort any MUL_WAIT on reset assertion mid-operation and resume in RUN on the first edge after release.

Configuration
REQ-029 SHALL, with MUL_MULTICYCLE_EN defined, implement MUL_WAIT, cnt and EX_hold_o as specified.
REQ-030 SHALL, without MUL_MULTICYCLE_EN, omit MUL_WAIT and cnt, tie EX_hold_o=0, and treat MUL as a single-cycle ALU op.

Verification
REQ-031 SHALL cover LW $2 in ID/EX, ADD using $2 as rs in IF/ID -> one cycle with pc_write_o=0 and IDEX_bubble_o=1, then normal operation and stall_cnt_o=1.
REQ-032 SHALL cover LW $0 in ID/EX with a dependent use of $0 -> no stall.
REQ-033 SHALL cover MUL in ID/EX with MUL_CYCLES=4 -> EX_hold_o high for 3 cycles, low on the 4th, and stall_cnt_o incremented by 3.
REQ-034 SHALL cover BEQ in ID with branch_eq_i=1 and a simultaneous load_use -> no flush that cycle, then IFID_flush_o=1 on the next cycle.
REQ-035 SHALL cover rst_n_i asserted in the 2nd MUL_WAIT cycle -> outputs go to reset values immediately, and state is RUN after release.
REQ-036 SHALL cover 70000 forced stall cycles -> stall_cnt_o saturates and holds at 16'hFFFF.

Source files
------------

// File: rtl/hazard_control.sv
// hazard_control: pipeline hazard unit for the five-stage core.
// Detects load-use hazards, flushes IF/ID on taken jumps/branches and,
// when MUL_MULTICYCLE_EN is defined, holds the pipeline while a
// multi-cycle MUL occupies EX. Without MUL_MULTICYCLE_EN the MUL is a
// plain single-cycle ALU op and EX_hold_o is tied low.
// Also keeps a saturating count of cycles in which the PC was frozen.
module hazard_control #(
    parameter int MUL_CYCLES = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [5:0]  ID_op_i,
    input  logic [4:0]  IFID_rs_i,
    input  logic [4:0]  IFID_rt_i,
    input  logic        branch_eq_i,
    input  logic [5:0]  IDEX_op_i,
    input  logic [1:0]  IDEX_MEM_ctrl_i,
    input  logic [4:0]  IDEX_rt_i,
    output logic        pc_write_o,
    output logic        IFID_write_o,
    output logic        IFID_flush_o,
    output logic        IDEX_bubble_o,
    output logic        EX_hold_o,
    output logic [15:0] stall_cnt_o
);

    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_BEQ = 6'h04;

    // The hold counter is 4 bits wide, so only 2..15 cycles make sense.
    if ((MUL_CYCLES < 2) || (MUL_CYCLES > 15)) begin : g_bad_mul_cycles
        $error("hazard_control: MUL_CYCLES must be in 2..15");
    end

    logic load_use;
    logic take_branch;
    logic mul_hold;

    // A load (cs=1, we=0) whose destination feeds the next instruction;
    // $0 is hardwired, so it never creates a dependency.
    assign load_use = IDEX_MEM_ctrl_i[1] & ~IDEX_MEM_ctrl_i[0]
                    & (IDEX_rt_i != 5'd0)
                    & ((IDEX_rt_i == IFID_rs_i) | (IDEX_rt_i == IFID_rt_i));

    assign take_branch = (ID_op_i == OP_J) | ((ID_op_i == OP_BEQ) & branch_eq_i);

`ifdef MUL_MULTICYCLE_EN
    localparam logic [5:0] OP_MUL   = 6'h1C;
    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 2);

    typedef enum logic {RUN, MUL_WAIT} state_t;

    state_t     state;
    state_t     next_state;
    logic [3:0] cnt;
    logic [3:0] cnt_next;

    // State register and remaining-hold counter.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    // The detecting cycle plus MUL_CYCLES-2 wait cycles give MUL_CYCLES-1 hold cycles.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        mul_hold   = 1'b0;
        case (state)
            RUN: begin
                if (IDEX_op_i == OP_MUL) begin
                    mul_hold   = 1'b1;
                    cnt_next   = MUL_LOAD;
                    next_state = MUL_WAIT;
                end
            end
            MUL_WAIT: begin
                if (cnt != 4'd0) begin
                    mul_hold = 1'b1;
                    cnt_next = cnt - 4'd1;
                end else begin
                    next_state = RUN;
                end
            end
            default: next_state = RUN;
        endcase
    end
`else
    logic unused_idex_op;

    assign mul_hold       = 1'b0;
    assign unused_idex_op = ^IDEX_op_i;
`endif

    // Priority: MUL hold, then load-use bubble, then jump/branch flush; reset overrides all.
    always_comb begin
        pc_write_o    = 1'b1;
        IFID_write_o  = 1'b1;
        IFID_flush_o  = 1'b0;
        IDEX_bubble_o = 1'b0;
        EX_hold_o     = 1'b0;
        if (mul_hold) begin
            EX_hold_o    = 1'b1;
            pc_write_o   = 1'b0;
            IFID_write_o = 1'b0;
        end else if (load_use) begin
            pc_write_o    = 1'b0;
            IFID_write_o  = 1'b0;
            IDEX_bubble_o = 1'b1;
        end else if (take_branch) begin
            IFID_flush_o = 1'b1;
        end
        if (!rst_n_i) begin
            pc_write_o    = 1'b0;
            IFID_write_o  = 1'b0;
            IFID_flush_o  = 1'b0;
            IDEX_bubble_o = 1'b1;
            EX_hold_o     = 1'b0;
        end
    end

    // Count frozen-PC cycles, sticking at all-ones.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_o <= 16'd0;
        end else if (!pc_write_o && (stall_cnt_o != 16'hFFFF)) begin
            stall_cnt_o <= stall_cnt_o + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_control.sv
// tb_hazard_control: directed bench for hazard_control (MUL_CYCLES=4).
// Expectations follow the MUL_MULTICYCLE_EN setting of the build.
module tb_hazard_control;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_MUL   = 6'h1C;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [1:0] MEM_NONE = 2'b00;
    localparam logic [1:0] MEM_LD   = 2'b10;
    localparam logic [1:0] MEM_ST   = 2'b11;

`ifdef MUL_MULTICYCLE_EN
    localparam logic MC = 1'b1;
`else
    localparam logic MC = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [5:0]  ID_op_i;
    logic [4:0]  IFID_rs_i;
    logic [4:0]  IFID_rt_i;
    logic        branch_eq_i;
    logic [5:0]  IDEX_op_i;
    logic [1:0]  IDEX_MEM_ctrl_i;
    logic [4:0]  IDEX_rt_i;
    logic        pc_write_o;
    logic        IFID_write_o;
    logic        IFID_flush_o;
    logic        IDEX_bubble_o;
    logic        EX_hold_o;
    logic [15:0] stall_cnt_o;

    int n_compared   = 0;
    int n_mismatched = 0;
    int sat_start;

    hazard_control #(.MUL_CYCLES(4)) dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .ID_op_i         (ID_op_i),
        .IFID_rs_i       (IFID_rs_i),
        .IFID_rt_i       (IFID_rt_i),
        .branch_eq_i     (branch_eq_i),
        .IDEX_op_i       (IDEX_op_i),
        .IDEX_MEM_ctrl_i (IDEX_MEM_ctrl_i),
        .IDEX_rt_i       (IDEX_rt_i),
        .pc_write_o      (pc_write_o),
        .IFID_write_o    (IFID_write_o),
        .IFID_flush_o    (IFID_flush_o),
        .IDEX_bubble_o   (IDEX_bubble_o),
        .EX_hold_o       (EX_hold_o),
        .stall_cnt_o     (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic drive(input logic [5:0] id_op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic beq, input logic [5:0] ex_op, input logic [1:0] mem,
                         input logic [4:0] ex_rt);
        ID_op_i         = id_op;
        IFID_rs_i       = rs;
        IFID_rt_i       = rt;
        branch_eq_i     = beq;
        IDEX_op_i       = ex_op;
        IDEX_MEM_ctrl_i = mem;
        IDEX_rt_i       = ex_rt;
    endtask

    task automatic applyStimulus(input logic [5:0] id_op, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic beq, input logic [5:0] ex_op, input logic [1:0] mem,
                                 input logic [4:0] ex_rt);
        @(posedge clk_i);
        #1;
        drive(id_op, rs, rt, beq, ex_op, mem, ex_rt);
        #4;
    endtask

    task automatic compareBit(input string tag, input logic obs, input logic exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkCount(input string tag, input logic [15:0] exp);
        n_compared++;
        assert (stall_cnt_o === exp) else begin
            n_mismatched++;
            $error("[TB] FAIL %s stall_cnt observed=%0h expected=%0h", tag, stall_cnt_o, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic pcw, input logic ifw,
                               input logic fl, input logic bub, input logic hold);
        compareBit({tag, ".pc_write"},    pc_write_o,    pcw);
        compareBit({tag, ".IFID_write"},  IFID_write_o,  ifw);
        compareBit({tag, ".IFID_flush"},  IFID_flush_o,  fl);
        compareBit({tag, ".IDEX_bubble"}, IDEX_bubble_o, bub);
        compareBit({tag, ".EX_hold"},     EX_hold_o,     hold);
    endtask

    initial begin
        rst_n_i = 1'b0;
        drive(OP_J, 5'd0, 5'd0, 1'b0, OP_RTYPE, MEM_NONE, 5'd0);
        #3;
        checkOutput("reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkCount("reset", 16'd0);

        #9;
        drive(OP_RTYPE, 5'd1, 5'd4, 1'b0, OP_RTYPE, MEM_NONE, 5'd0);
        rst_n_i = 1'b1;

        applyStimulus(OP_RTYPE, 5'd1, 5'd4, 1'b0, OP_RTYPE, MEM_NONE, 5'd0);
        checkOutput("idle", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkCount("idle", 16'd0);

        applyStimulus(OP_RTYPE, 5'd2, 5'd7, 1'b0, OP_LW, MEM_LD, 5'd2);
        checkOutput("lu_rs", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        applyStimulus(OP_RTYPE, 5'd2, 5'd7, 1'b0, OP_RTYPE, MEM_NONE, 5'd0);
        checkOutput("after_lu", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkCount("after_lu", 16'd1);

        applyStimulus(OP_RTYPE, 5'd0, 5'd0, 1'b0, OP_LW, MEM_LD, 5'd0);
        checkOutput("lu_r0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        applyStimulus(OP_RTYPE, 5'd9, 5'd5, 1'b0, OP_SW, MEM_ST, 5'd5);
        checkOutput("store_rt", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        applyStimulus(OP_RTYPE, 5'd9, 5'd6, 1'b0, OP_LW, MEM_LD, 5'd6);
        checkOutput("lu_rt", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        applyStimulus(OP_BEQ, 5'd3, 5'd8, 1'b1, OP_LW, MEM_LD, 5'd3);
        checkOutput("beq_lu", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        applyStimulus(OP_BEQ, 5'd3, 5'd8, 1'b1, OP_RTYPE, MEM_NONE, 5'd0);
        checkOutput("beq_retry", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checkCount("beq_retry", 16'd3);

        applyStimulus(OP_J, 5'd0, 5'd0, 1'b0, OP_RTYPE, MEM_NONE, 5'd0);
        checkOutput("jump", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        applyStimulus(OP_BEQ, 5'd3, 5'd8, 1'b0, OP_RTYPE, MEM_NONE, 5'd0);
        checkOutput("beq_nt", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        applyStimulus(OP_RTYPE, 5'd1, 5'd2, 1'b0, OP_MUL, MEM_NONE, 5'd9);
        checkOutput("mul_a", ~MC, ~MC, 1'b0, 1'b0, MC);
        applyStimulus(OP_J, 5'd1, 5'd2, 1'b0, OP_MUL, MEM_NONE, 5'd9);
        checkOutput("mul_b", ~MC, ~MC, ~MC, 1'b0, MC);
        applyStimulus(OP_RTYPE, 5'd1, 5'd2, 1'b0, OP_MUL, MEM_NONE, 5'd9);
        checkOutput("mul_c", ~MC, ~MC, 1'b0, 1'b0, MC);
        applyStimulus(OP_J, 5'd1, 5'd2, 1'b0, OP_MUL, MEM_NONE, 5'd9);
        checkOutput("mul_d", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(OP_RTYPE, 5'd1, 5'd2, 1'b0, OP_RTYPE, MEM_NONE, 5'd0);
        checkOutput("mul_e", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkCount("mul_e", MC ? 16'd6 : 16'd3);

        applyStimulus(OP_RTYPE, 5'd1, 5'd2, 1'b0, OP_MUL, MEM_NONE, 5'd9);
        checkOutput("rmul_a", ~MC, ~MC, 1'b0, 1'b0, MC);
        applyStimulus(OP_RTYPE, 5'd1, 5'd2, 1'b0, OP_MUL, MEM_NONE, 5'd9);
        checkOutput("rmul_b", ~MC, ~MC, 1'b0, 1'b0, MC);
        applyStimulus(OP_RTYPE, 5'd1, 5'd2, 1'b0, OP_MUL, MEM_NONE, 5'd9);
        checkOutput("rmul_c", ~MC, ~MC, 1'b0, 1'b0, MC);
        #1;
        rst_n_i = 1'b0;
        #1;
        checkOutput("rst_mid", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkCount("rst_mid", 16'd0);
        #1;
        rst_n_i = 1'b1;
        #1;
        checkOutput("rel_a", ~MC, ~MC, 1'b0, 1'b0, MC);
        applyStimulus(OP_RTYPE, 5'd1, 5'd2, 1'b0, OP_MUL, MEM_NONE, 5'd9);
        checkOutput("rel_b", ~MC, ~MC, 1'b0, 1'b0, MC);
        applyStimulus(OP_RTYPE, 5'd1, 5'd2, 1'b0, OP_MUL, MEM_NONE, 5'd9);
        checkOutput("rel_c", ~MC, ~MC, 1'b0, 1'b0, MC);
        applyStimulus(OP_RTYPE, 5'd1, 5'd2, 1'b0, OP_MUL, MEM_NONE, 5'd9);
        checkOutput("rel_d", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkCount("rel_d", MC ? 16'd3 : 16'd0);
        applyStimulus(OP_RTYPE, 5'd1, 5'd2, 1'b0, OP_RTYPE, MEM_NONE, 5'd0);
        checkOutput("rel_e", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkCount("rel_e", MC ? 16'd3 : 16'd0);

        sat_start = MC ? 3 : 0;
        applyStimulus(OP_RTYPE, 5'd4, 5'd0, 1'b0, OP_LW, MEM_LD, 5'd4);
        checkOutput("sat_lu", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (65534 - sat_start) @(posedge clk_i);
        #1;
        checkCount("sat_fffe", 16'hFFFE);
        @(posedge clk_i);
        #1;
        checkCount("sat_ffff", 16'hFFFF);
        repeat (4600) @(posedge clk_i);
        #1;
        checkCount("sat_hold", 16'hFFFF);

        applyStimulus(OP_RTYPE, 5'd4, 5'd0, 1'b0, OP_RTYPE, MEM_NONE, 5'd0);
        checkOutput("sat_end", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(OP_RTYPE, 5'd4, 5'd0, 1'b0, OP_RTYPE, MEM_NONE, 5'd0);
        checkCount("sat_end", 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
